// File: rtl/spike_window_classifier.sv
// spike_window_classifier
// Counts per-neuron output spikes over a window of delay_clk ticks, then
// holds the counts, a winner index and a tie flag behind a valid/ack
// handshake until the consumer acknowledges.

module spike_window_classifier #(
  parameter int NUM_OUT = 2,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 8
) (
  input  logic                                           system_clock,
  input  logic                                           rst_n,
  input  logic                                           enable,
  input  logic                                           start,
  input  logic [WIN_W-1:0]                               window_len,
  input  logic                                           delay_clk,
  input  logic [NUM_OUT-1:0]                             output_spikes,
  input  logic                                           result_ack,
  output logic                                           busy,
  output logic                                           result_valid,
  output logic [NUM_OUT*CNT_W-1:0]                       spike_counts,
  output logic [((NUM_OUT > 1) ? $clog2(NUM_OUT) : 1)-1:0] winner,
  output logic                                           tie,
  output logic                                           overflow
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic             delay_clk_q;
  logic [WIN_W-1:0] remaining;
  logic [CNT_W-1:0] cnt_q [NUM_OUT];
  logic             tick;

  logic [CNT_W-1:0] max_cnt;
  logic [IDX_W-1:0] win_idx;
  int               n_at_max;

  // A tick is a rising edge of the divided clock seen in the system_clock domain.
  assign tick = delay_clk & ~delay_clk_q;

  // Window control, per-neuron saturating counters and the sticky overflow flag.
  // NOTE: every register here is written with <= so all updates take effect
  // together on the edge; blocking writes would let later statements see
  // already-updated values and break the count/remaining/state alignment.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      delay_clk_q <= 1'b0;
      remaining   <= '0;
      overflow    <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset along with the rest; reset outputs must read zero immediately.
      cnt_q       <= '{default: '0};
    end else begin
      delay_clk_q <= delay_clk;
      case (state)
        IDLE: begin
          if (start && enable) begin
            cnt_q     <= '{default: '0};
            overflow  <= 1'b0;
            remaining <= window_len;
            state     <= (window_len == '0) ? DONE : COUNT;
          end
        end
        COUNT: begin
          if (tick && enable) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (output_spikes[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                  overflow <= 1'b1;
                end else begin
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
              end
            end
            remaining <= remaining - WIN_W'(1);
            if (remaining == WIN_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (result_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Winner is the lowest index at the maximum; tie when the maximum is shared.
  // NOTE: every variable gets a value before the loops so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    max_cnt  = cnt_q[0];
    win_idx  = '0;
    n_at_max = 0;
    for (int i = 1; i < NUM_OUT; i++) begin
      if (cnt_q[i] > max_cnt) begin
        max_cnt = cnt_q[i];
        win_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      if (cnt_q[i] == max_cnt) begin
        n_at_max = n_at_max + 1;
      end
    end
  end

  // Flatten the counter array onto the packed result bus.
  always_comb begin
    spike_counts = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      spike_counts[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign winner       = win_idx;
  assign tie          = (n_at_max > 1) || (max_cnt == '0);
  assign busy         = (state == COUNT);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_spike_window_classifier.sv
// Self-checking bench for spike_window_classifier (2 neurons, 8-bit counters,
// 9-bit window so a single window can run past counter saturation).
// A behavioural model follows the driven stimulus, pushes the expected result
// when a window ends, and the result is popped and compared once result_valid
// shows up.

module tb_spike_window_classifier;

  localparam int NUM_OUT = 2;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  logic                     clk;
  logic                     rst_n;
  logic                     enable;
  logic                     start;
  logic [WIN_W-1:0]         window_len;
  logic                     delay_clk;
  logic [NUM_OUT-1:0]       output_spikes;
  logic                     result_ack;
  logic                     busy;
  logic                     result_valid;
  logic [NUM_OUT*CNT_W-1:0] spike_counts;
  logic                     winner;
  logic                     tie;
  logic                     overflow;

  spike_window_classifier #(
    .NUM_OUT(NUM_OUT),
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W)
  ) dut (
    .system_clock (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .start        (start),
    .window_len   (window_len),
    .delay_clk    (delay_clk),
    .output_spikes(output_spikes),
    .result_ack   (result_ack),
    .busy         (busy),
    .result_valid (result_valid),
    .spike_counts (spike_counts),
    .winner       (winner),
    .tie          (tie),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {M_IDLE, M_COUNT, M_DONE} m_state_t;

  typedef struct {
    logic [NUM_OUT*CNT_W-1:0] counts;
    logic                     winner;
    logic                     tie;
    logic                     ovf;
  } exp_t;

  exp_t sb[$];

  m_state_t         m_state;
  logic [CNT_W-1:0] m_cnt [NUM_OUT];
  logic             m_ovf;
  int               m_rem;

  int n_cmp;
  int n_err;

  function automatic logic [NUM_OUT*CNT_W-1:0] m_packed();
    return {m_cnt[1], m_cnt[0]};
  endfunction

  // Push the expected result of the window the model just closed.
  task automatic push_expected();
    exp_t e;
    e.counts = m_packed();
    e.winner = (m_cnt[1] > m_cnt[0]);
    e.tie    = (m_cnt[0] == m_cnt[1]);
    e.ovf    = m_ovf;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_cnt[0] = '0;
    m_cnt[1] = '0;
    m_ovf    = 1'b0;
    m_rem    = 0;
    sb.delete();
  endtask

  // Pulse start for one cycle; the model accepts it only in IDLE with enable.
  task automatic do_start(input logic [WIN_W-1:0] len);
    @(negedge clk);
    start      = 1'b1;
    window_len = len;
    if (m_state == M_IDLE && enable) begin
      m_cnt[0] = '0;
      m_cnt[1] = '0;
      m_ovf    = 1'b0;
      m_rem    = int'(len);
      if (len == '0) begin
        m_state = M_DONE;
        push_expected();
      end else begin
        m_state = M_COUNT;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== (m_state == M_COUNT) || result_valid !== (m_state == M_DONE)) begin
      n_err++;
      $display("FAIL start_state: busy=%b valid=%b want busy=%b valid=%b",
               busy, result_valid, m_state == M_COUNT, m_state == M_DONE);
    end
    n_cmp++;
    if (spike_counts !== m_packed() || overflow !== m_ovf) begin
      n_err++;
      $display("FAIL start_counts: counts=%h ovf=%b want counts=%h ovf=%b",
               spike_counts, overflow, m_packed(), m_ovf);
    end
  endtask

  // One delay_clk period of `period` system clocks; spikes shown on the tick edge only.
  task automatic drive_tick(input logic [NUM_OUT-1:0] sp, input int period);
    @(negedge clk);
    delay_clk     = 1'b1;
    output_spikes = sp;
    if (m_state == M_COUNT && enable) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (sp[i]) begin
          if (m_cnt[i] == CNT_MAX) m_ovf = 1'b1;
          else m_cnt[i] = m_cnt[i] + 8'd1;
        end
      end
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_state = M_DONE;
        push_expected();
      end
    end
    @(negedge clk);
    output_spikes = '0;
    n_cmp++;
    if (busy !== (m_state == M_COUNT) || result_valid !== (m_state == M_DONE)) begin
      n_err++;
      $display("FAIL tick_state: busy=%b valid=%b want busy=%b valid=%b",
               busy, result_valid, m_state == M_COUNT, m_state == M_DONE);
    end
    repeat (period / 2 - 1) @(negedge clk);
    delay_clk = 1'b0;
    repeat (period - period / 2 - 1) @(negedge clk);
  endtask

  // Scoreboard drain: wait (bounded) for result_valid, pop and compare.
  task automatic sb_compare_result(input string name);
    exp_t e;
    int   waited;
    waited = 0;
    while (result_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_valid: result_valid=%b want 1 (timeout)", name, result_valid);
      return;
    end
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb: result_valid=1 with no expected result queued", name);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (spike_counts !== e.counts) begin
      n_err++;
      $display("FAIL %s_counts: got %h want %h", name, spike_counts, e.counts);
    end
    n_cmp++;
    if (winner !== e.winner) begin
      n_err++;
      $display("FAIL %s_winner: got %b want %b", name, winner, e.winner);
    end
    n_cmp++;
    if (tie !== e.tie) begin
      n_err++;
      $display("FAIL %s_tie: got %b want %b", name, tie, e.tie);
    end
    n_cmp++;
    if (overflow !== e.ovf) begin
      n_err++;
      $display("FAIL %s_overflow: got %b want %b", name, overflow, e.ovf);
    end
  endtask

  // Acknowledge, optionally with a simultaneous start that must be ignored.
  task automatic do_ack(input logic with_start);
    @(negedge clk);
    result_ack = 1'b1;
    start      = with_start;
    window_len = 9'd5;
    if (m_state == M_DONE) m_state = M_IDLE;
    @(negedge clk);
    result_ack = 1'b0;
    start      = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ack_state: valid=%b busy=%b want 0 0", result_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || spike_counts !== m_packed()) begin
      n_err++;
      $display("FAIL ack_idle_hold: busy=%b counts=%h want busy=0 counts=%h",
               busy, spike_counts, m_packed());
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    enable        = 1'b1;
    start         = 1'b0;
    window_len    = '0;
    delay_clk     = 1'b0;
    output_spikes = '0;
    result_ack    = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b valid=%b ovf=%b want 0 0 0", busy, result_valid, overflow);
    end
    n_cmp++;
    if (spike_counts !== '0 || winner !== 1'b0 || tie !== 1'b1) begin
      n_err++;
      $display("FAIL reset_result: counts=%h winner=%b tie=%b want 0 0 1", spike_counts, winner, tie);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_start(9'd4);
    drive_tick(2'b01, 4);
    drive_tick(2'b01, 4);
    drive_tick(2'b11, 4);
    drive_tick(2'b01, 4);
    sb_compare_result("basic");
    do_ack(1'b0);
  endtask

  task automatic test_tie_zero();
    do_start(9'd3);
    drive_tick(2'b11, 4);
    drive_tick(2'b10, 4);
    drive_tick(2'b01, 4);
    sb_compare_result("tie");
    do_ack(1'b0);
    do_start(9'd3);
    repeat (3) drive_tick(2'b00, 4);
    sb_compare_result("zero");
    do_ack(1'b0);
    do_start(9'd2);
    drive_tick(2'b10, 4);
    drive_tick(2'b10, 4);
    sb_compare_result("win1");
    do_ack(1'b0);
  endtask

  task automatic test_saturation();
    do_start(9'd300);
    repeat (10) drive_tick(2'b11, 2);
    repeat (290) drive_tick(2'b10, 2);
    sb_compare_result("saturate");
    do_ack(1'b0);
    do_start(9'd1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL sat_clear: overflow=%b want 0", overflow);
    end
    drive_tick(2'b00, 2);
    sb_compare_result("sat_next");
    do_ack(1'b0);
  endtask

  task automatic test_pause();
    do_start(9'd6);
    drive_tick(2'b01, 4);
    drive_tick(2'b01, 4);
    do_start(9'd2);
    @(negedge clk);
    enable = 1'b0;
    repeat (10) drive_tick(2'b11, 4);
    @(negedge clk);
    enable = 1'b1;
    repeat (4) drive_tick(2'b10, 4);
    do_start(9'd3);
    sb_compare_result("pause");
    do_ack(1'b1);
  endtask

  task automatic test_len0_handshake();
    logic [NUM_OUT*CNT_W-1:0] held;
    do_start(9'd0);
    held = m_packed();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (result_valid !== 1'b1 || spike_counts !== held || winner !== 1'b0 || tie !== 1'b1) begin
        n_err++;
        $display("FAIL len0_hold[%0d]: valid=%b counts=%h winner=%b tie=%b want 1 %h 0 1",
                 c, result_valid, spike_counts, winner, tie, held);
      end
    end
    sb_compare_result("len0");
    do_ack(1'b0);
  endtask

  task automatic test_reset_mid();
    do_start(9'd10);
    repeat (3) drive_tick(2'b11, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_flags: busy=%b valid=%b ovf=%b want 0 0 0", busy, result_valid, overflow);
    end
    n_cmp++;
    if (spike_counts !== '0 || winner !== 1'b0 || tie !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_result: counts=%h winner=%b tie=%b want 0 0 1", spike_counts, winner, tie);
    end
    model_reset();
    delay_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive_tick(2'b11, 4);
    do_start(9'd2);
    drive_tick(2'b01, 4);
    drive_tick(2'b01, 4);
    sb_compare_result("post_reset");
    do_ack(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_tie_zero();
    test_saturation();
    test_pause();
    test_len0_handshake();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected results never produced, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
